// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues reads to a 1-cycle synchronous memory and buffers
// returned words in a 2-entry FIFO. Define IFETCH_PERF_EN to add fetch/stall counters.
module instr_fetch #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic [31:0]       code,
    output logic              code_valid,
    input  logic              code_ready,
    output logic [ADDR_W-1:0] code_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              halted
`ifdef IFETCH_PERF_EN
    ,
    output logic [15:0]       fetch_cnt,
    output logic [15:0]       stall_cnt
`endif
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;
    localparam logic [5:0] HALT_OP  = 6'h3f;

    logic [1:0]        state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;

    logic [ADDR_W-1:0] fifo_pc   [2];
    logic [31:0]       fifo_word [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;

    logic              pop;
    logic              push;
    logic              halt_return;
    logic [2:0]        occupancy;
    logic              room;

    assign code_valid  = (count != 2'd0);
    assign pop         = code_valid & code_ready;
    assign push        = inflight & ~redirect;
    assign halt_return = inflight & (imem_data[31:26] == HALT_OP);
    assign occupancy   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign room        = (occupancy < 3'd2);

    // A returning HALT word blocks the request that would otherwise issue alongside it,
    // so nothing past the HALT address is ever fetched.
    assign imem_req  = ~rst & (state == ST_RUN) & ~redirect & ~halt_return & room;
    assign imem_addr = imem_req ? fetch_pc : '0;

    assign code    = code_valid ? fifo_word[rd_ptr] : '0;
    assign code_pc = code_valid ? fifo_pc[rd_ptr]   : '0;
    assign halted  = (state == ST_HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= imem_req;
            if (redirect) begin
                fetch_pc <= redirect_addr;
            end else if (imem_req) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + ADDR_W'(1);
            end
        end
    end

    // Redirect wins over everything: a transfer in the same cycle still completes,
    // then the FIFO and any in-flight response are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else if (redirect) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= inflight_pc;
            fifo_word[wr_ptr] <= imem_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else if (redirect) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN:   if (push && imem_data[31:26] == HALT_OP) state <= ST_DRAIN;
                ST_DRAIN: if (pop && code[31:26] == HALT_OP)       state <= ST_HALT;
                ST_HALT:  state <= ST_HALT;
                default:  state <= ST_RUN;
            endcase
        end
    end

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt <= 16'd0;
            stall_cnt <= 16'd0;
        end else begin
            if (pop && fetch_cnt != 16'hFFFF)
                fetch_cnt <= fetch_cnt + 16'd1;
            if (code_valid && !code_ready && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: cycle table, transfer scoreboard and hand sequences
// for redirect, halt, mid-run reset and (with IFETCH_PERF_EN) the performance counters.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        code_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_addr = 8'h00;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] code;
    logic        code_valid;
    logic [7:0]  code_pc;
    logic        halted;

    logic        b_req;
    logic [3:0]  b_addr;
    logic [31:0] b_data;
    logic [31:0] b_code;
    logic        b_valid;
    logic [3:0]  b_pc;
    logic        b_halted;

`ifdef IFETCH_PERF_EN
    logic [15:0] fetch_cnt, stall_cnt, b_fetch_cnt, b_stall_cnt;
`endif

    int   vectors = 0;
    int   miscompares = 0;
    logic halt_en = 1'b0;
    logic halt_watch = 1'b0;
    int   bad_req = 0;
    logic b_en = 1'b0;
    int   b_log[$];

    typedef struct {
        logic [7:0]  pc;
        logic [31:0] word;
    } sb_t;
    sb_t sb_q[$];
    sb_t sb_e;

    typedef struct {
        logic       rdy;
        logic       rd;
        logic [7:0] ra;
        logic       exp_req;
        logic [7:0] exp_addr;
        logic       exp_valid;
        logic [7:0] exp_pc;
    } vec_t;
    vec_t vecs[17];

    instr_fetch #(.ADDR_W(8), .RESET_PC(8'd0)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
        .code(code), .code_valid(code_valid), .code_ready(code_ready), .code_pc(code_pc),
        .redirect(redirect), .redirect_addr(redirect_addr), .halted(halted)
`ifdef IFETCH_PERF_EN
        , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
    );

    instr_fetch #(.ADDR_W(4), .RESET_PC(4'd14)) dut_b (
        .clk(clk), .rst(rst),
        .imem_req(b_req), .imem_addr(b_addr), .imem_data(b_data),
        .code(b_code), .code_valid(b_valid), .code_ready(1'b1), .code_pc(b_pc),
        .redirect(1'b0), .redirect_addr(4'h0), .halted(b_halted)
`ifdef IFETCH_PERF_EN
        , .fetch_cnt(b_fetch_cnt), .stall_cnt(b_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        if (halt_en && a == 8'd3) return 32'hFC00_0000;
        return 32'h1000_0000 | {24'h0, a};
    endfunction

    always @(posedge clk) imem_data <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    always @(posedge clk) b_data    <= b_req ? {28'h0, b_addr} : 32'hDEAD_BEEF;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && code_valid && code_ready) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL sb_unexpected: got transfer pc 0x%0h, expected none", code_pc);
            end else begin
                sb_e = sb_q.pop_front();
                checkOutput("sb_pc", {24'h0, code_pc}, {24'h0, sb_e.pc});
                checkOutput("sb_code", code, sb_e.word);
            end
        end
        if (halt_watch && imem_req && imem_addr > 8'd3) bad_req++;
        if (b_en && !rst && b_valid) begin
            b_log.push_back(int'(b_pc));
            checkOutput("b_code", b_code, {28'h0, b_pc});
        end
    end

    task automatic sbLoad(input logic [7:0] start, input int n);
        sb_q.delete();
        for (int i = 0; i < n; i++) begin
            sb_t e;
            e.pc   = start + 8'(i);
            e.word = mem_word(e.pc);
            sb_q.push_back(e);
        end
    endtask

    // Drive just after the rising edge, then return just after the falling edge for sampling.
    task automatic applyStimulus(input logic r, input logic rdy, input logic rd, input logic [7:0] ra);
        @(posedge clk);
        #1;
        rst = r;
        code_ready = rdy;
        redirect = rd;
        redirect_addr = ra;
        @(negedge clk);
        #1;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_req"},   {31'h0, imem_req},   32'h0);
        checkOutput({tag, "_addr"},  {24'h0, imem_addr},  32'h0);
        checkOutput({tag, "_code"},  code,                32'h0);
        checkOutput({tag, "_valid"}, {31'h0, code_valid}, 32'h0);
        checkOutput({tag, "_pc"},    {24'h0, code_pc},    32'h0);
        checkOutput({tag, "_halted"},{31'h0, halted},     32'h0);
`ifdef IFETCH_PERF_EN
        checkOutput({tag, "_fetch_cnt"}, {16'h0, fetch_cnt}, 32'h0);
        checkOutput({tag, "_stall_cnt"}, {16'h0, stall_cnt}, 32'h0);
`endif
    endtask

    function automatic vec_t mk(input logic rdy, input logic rd, input logic [7:0] ra,
                                input logic req, input logic [7:0] addr,
                                input logic vld, input logic [7:0] pc);
        vec_t v;
        v.rdy = rdy; v.rd = rd; v.ra = ra;
        v.exp_req = req; v.exp_addr = addr; v.exp_valid = vld; v.exp_pc = pc;
        return v;
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int b_exp[4];
        logic [31:0] exp_code;
        b_exp = '{14, 15, 0, 1};

        // Startup, stall of five cycles, then a redirect landing on a live transfer
        vecs[0]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00);
        vecs[1]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 8'h00);
        vecs[2]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 8'h00);
        vecs[3]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 8'h01);
        for (int i = 4; i <= 8; i++)
            vecs[i] = mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h02);
        vecs[9]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h04, 1'b1, 8'h02);
        vecs[10] = mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h05, 1'b1, 8'h03);
        vecs[11] = mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h06, 1'b1, 8'h04);
        vecs[12] = mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h07, 1'b1, 8'h05);
        vecs[13] = mk(1'b1, 1'b1, 8'h80, 1'b0, 8'h00, 1'b1, 8'h06);
        vecs[14] = mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h80, 1'b0, 8'h00);
        vecs[15] = mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h81, 1'b0, 8'h00);
        vecs[16] = mk(1'b1, 1'b0, 8'h00, 1'b1, 8'h82, 1'b1, 8'h80);

        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkReset("rst_init");
        sbLoad(8'h00, 32);
        b_log.delete();
        b_en = 1'b1;

        for (int k = 0; k < 17; k++) begin
            if (k > 0 && vecs[k-1].rd) sbLoad(vecs[k-1].ra, 32);
            applyStimulus(1'b0, vecs[k].rdy, vecs[k].rd, vecs[k].ra);
            exp_code = vecs[k].exp_valid ? mem_word(vecs[k].exp_pc) : 32'h0;
            checkOutput($sformatf("v%0d_req", k),   {31'h0, imem_req},   {31'h0, vecs[k].exp_req});
            checkOutput($sformatf("v%0d_addr", k),  {24'h0, imem_addr},  {24'h0, vecs[k].exp_addr});
            checkOutput($sformatf("v%0d_valid", k), {31'h0, code_valid}, {31'h0, vecs[k].exp_valid});
            checkOutput($sformatf("v%0d_pc", k),    {24'h0, code_pc},    {24'h0, vecs[k].exp_pc});
            checkOutput($sformatf("v%0d_code", k),  code,                exp_code);
        end

        b_en = 1'b0;
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("b_order%0d", i),
                        (i < b_log.size()) ? b_log[i] : 32'hFFFF_FFFF, b_exp[i]);
        checkOutput("b_halted", {31'h0, b_halted}, 32'h0);

        // Reset in the middle of streaming; the stale response must not surface
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkReset("rst_mid");
        sbLoad(8'h00, 32);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("mid_c0_req",  {31'h0, imem_req},  32'h1);
        checkOutput("mid_c0_addr", {24'h0, imem_addr}, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("mid_c1_valid", {31'h0, code_valid}, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("mid_c2_valid", {31'h0, code_valid}, 32'h1);
        checkOutput("mid_c2_pc",    {24'h0, code_pc},    32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);

        // Redirect while one word is buffered and one is in flight
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        sbLoad(8'h40, 32);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("rd_c1_addr", {24'h0, imem_addr}, 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h40);
        checkOutput("rd_c2_req",   {31'h0, imem_req},   32'h0);
        checkOutput("rd_c2_valid", {31'h0, code_valid}, 32'h1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("rd_c3_valid", {31'h0, code_valid}, 32'h0);
        checkOutput("rd_c3_addr",  {24'h0, imem_addr},  32'h40);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("rd_c4_valid", {31'h0, code_valid}, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("rd_c5_valid", {31'h0, code_valid}, 32'h1);
        checkOutput("rd_c5_pc",    {24'h0, code_pc},    32'h40);

        // HALT word at address 3
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        halt_en = 1'b1;
        sbLoad(8'h00, 4);
        bad_req = 0;
        halt_watch = 1'b1;
        for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("halt_c4_req", {31'h0, imem_req}, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("halt_c5_code",   code,               32'hFC00_0000);
        checkOutput("halt_c5_halted", {31'h0, halted},    32'h0);
        for (int c = 6; c < 10; c++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
            checkOutput($sformatf("halt_c%0d_halted", c), {31'h0, halted},     32'h1);
            checkOutput($sformatf("halt_c%0d_valid", c),  {31'h0, code_valid}, 32'h0);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h10);
        halt_watch = 1'b0;
        sbLoad(8'h10, 32);
        checkOutput("no_req_past_halt", bad_req, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("resume_halted", {31'h0, halted},    32'h0);
        checkOutput("resume_addr",   {24'h0, imem_addr}, 32'h10);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("resume_pc", {24'h0, code_pc}, 32'h10);
        halt_en = 1'b0;

`ifdef IFETCH_PERF_EN
        // Four stall cycles, then exactly ten transfers
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkReset("rst_perf");
        sbLoad(8'h00, 32);
        for (int c = 0; c < 6; c++)  applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        for (int c = 0; c < 10; c++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("perf_fetch_cnt", {16'h0, fetch_cnt}, 32'd10);
        checkOutput("perf_stall_cnt", {16'h0, stall_cnt}, 32'd4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: instruction-memory address width.
REQ-002 SHALL have parameter RESET_PC, default 0: first fetch address after reset.
REQ-003 SHALL have port clk  input  1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have port imem_req  output  1: read strobe to the synchronous instruction memory.
REQ-006 SHALL have port imem_addr  output  ADDR_W: read address, valid while imem_req=1.
REQ-007 SHALL have port imem_data  input  32: read data, valid exactly one cycle after imem_req=1.
REQ-008 SHALL have port code  output  32: instruction word presented to the decode/ALU stage.
REQ-009 SHALL have port code_valid  output  1: code holds a valid instruction.
REQ-010 SHALL have port code_ready  input  1: consumer accepts code this cycle.
REQ-011 SHALL have port code_pc  output  ADDR_W: fetch address of the word on code.
REQ-012 SHALL have port redirect  input  1: one-cycle jump/restart request.
REQ-013 SHALL have port redirect_addr  input  ADDR_W: new fetch address, sampled when redirect=1.
REQ-014 SHALL have port halted  output  1: HALT instruction has been consumed; fetching stopped.

Function
REQ-015 SHALL implement a 2-entry FIFO of {pc, word}; code/code_pc/code_valid driven from the head entry.
REQ-016 SHALL complete a transfer only on a cycle with code_valid=1 and code_ready=1; code SHALL stay stable while code_valid=1 and code_ready=0.
REQ-017 SHALL assert imem_req only when (entries + in-flight - pop this cycle) < 2, in state RUN, and with redirect=0.
REQ-018 SHALL increment fetch_pc by 1 per issued request, wrapping 2^ADDR_W-1 -> 0.
REQ-019 SHALL write imem_data into the FIFO on the cycle it returns; code_valid SHALL rise the following cycle (request-to-valid latency 2 cycles).
REQ-020 SHALL sustain one transfer per cycle when code_ready is held high.
REQ-021 SHALL have FSM states RUN, DRAIN and HALT: RUN -> DRAIN when a returned word has code[31:26]=6'b111111; DRAIN issues no requests; DRAIN -> HALT when that word is transferred; halted=1 only in HALT.
REQ-022 On redirect=1, SHALL flush the FIFO, discard any in-flight response, load fetch_pc from redirect_addr, and enter RUN from any state; the first new request SHALL issue the next cycle.
REQ-023 When redirect and a completed transfer occur in the same cycle, SHALL count the transfer as done and then apply the flush.
REQ-024 SHALL drive code_valid=0 in the cycle after redirect.
REQ-025 SHALL never overflow the FIFO and SHALL never present a popped or flushed entry.

Reset
REQ-026 While rst=1: imem_req=0, imem_addr=0, code=0, code_valid=0, code_pc=0, halted=0, FIFO empty, nothing in flight, state RUN, fetch_pc=RESET_PC.
REQ-027 SHALL issue its first request at RESET_PC on the first clock edge after rst deasserts.
REQ-028 SHALL discard any response to a request issued before a mid-operation reset.

Configuration
REQ-029 With macro IFETCH_PERF_EN defined, SHALL add outputs fetch_cnt[15:0] (transfers completed) and stall_cnt[15:0] (cycles with code_valid=1 and code_ready=0); both saturate at 16'hFFFF and reset to 0.
REQ-030 Without IFETCH_PERF_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-031 Reset release, memory holds word N at address N, code_ready=1 -> code_valid first high 2 cycles after the first request; code_pc = 0,1,2,... on consecutive cycles.
REQ-032 code_ready=0 for 5 cycles -> at most 2 words buffered, code and code_pc stable, imem_req=0; on release, transfers continue without loss or duplication.
REQ-033 ADDR_W=4, RESET_PC=14 -> fetch order 14,15,0,1.
REQ-034 redirect to 8'h40 while one word is in flight and one is buffered -> neither is presented; next code_pc=8'h40.
REQ-035 Word 32'hFC00_0000 at address 3 -> no request beyond address 3; halted=1 the cycle after word 3 transfers; a later redirect clears halted and fetching resumes.
REQ-036 With IFETCH_PERF_EN: 10 transfers and 4 stall cycles -> fetch_cnt=10, stall_cnt=4.
